// File: rtl/button_event_decoder.sv
// button_event_decoder
// Turns a clean, debounced button level into gesture events: short press,
// long press and double click, each a one-cycle registered pulse, plus a
// "held" level while a long press is in progress.
//
// Optional feature: define BTN_AUTOREPEAT_EN to emit repeat_tick every
// REPEAT_CYCLES while the button stays long-held. Without the macro the
// repeat_tick port stays present but is tied to 0 and no repeat counter
// logic is built.
//
// Handshake note: there is no valid/ready pair here. btn_level is sampled
// on every rising clk edge and every output is a registered level or a
// one-cycle pulse that downstream logic must take in the cycle it appears.
//
// Debug visibility: the FSM state is held in the signal "state"
// (type state_t). Checkers can bind to it hierarchically.

module button_event_decoder #(
  parameter int LONG_CYCLES   = 1000,
  parameter int GAP_CYCLES    = 300,
  parameter int REPEAT_CYCLES = 200,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic repeat_tick,
  output logic held
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT_GAP  = 3'd2,
    PRESS2    = 3'd3,
    LONG_HELD = 3'd4
  } state_t;

  // Terminal counts. The counter restarts from 0 on every state entry, so
  // a terminal value of N-1 means "N cycles spent in this state".
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             btn_prev;
  logic             rise;
  logic             short_nxt;
  logic             long_nxt;
  logic             dbl_nxt;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic tick_nxt;
`endif

  // btn_prev resets to 1, so a button already down at reset release does
  // not produce a rise until it has been released and pressed again.
  assign rise = btn_level & ~btn_prev;

  // Next-state, counter and pulse decode for the gesture FSM.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
    dbl_nxt   = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    tick_nxt  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PRESS1;
          cnt_nxt   = '0;
        end
      end
      PRESS1: begin
        // A release wins over a coincident long-press terminal count.
        if (!btn_level) begin
          state_nxt = WAIT_GAP;
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          long_nxt  = 1'b1;
          state_nxt = LONG_HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      WAIT_GAP: begin
        // A re-press wins over a coincident gap timeout.
        if (btn_level) begin
          state_nxt = PRESS2;
          cnt_nxt   = '0;
        end else if (cnt == GAP_LAST) begin
          short_nxt = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      PRESS2: begin
        // Second press of a double click: no timing, counter frozen.
        if (!btn_level) begin
          dbl_nxt   = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      LONG_HELD: begin
        if (!btn_level) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          if (cnt == REP_LAST) begin
            tick_nxt = 1'b1;
            cnt_nxt  = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
`else
          cnt_nxt = cnt;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter, edge-detect history and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      btn_prev     <= 1'b1;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      held         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      btn_prev     <= btn_level;
      short_press  <= short_nxt;
      long_press   <= long_nxt;
      double_click <= dbl_nxt;
      held         <= (state_nxt == LONG_HELD);
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  // Registered auto-repeat pulse while long-held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      repeat_tick <= 1'b0;
    end else begin
      repeat_tick <= tick_nxt;
    end
  end
`else
  assign repeat_tick = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder
// Randomized and directed stimulus for button_event_decoder, checked every
// cycle against a timestamp-based gesture model, plus literal expectations
// for the directed scenarios. Build with +define+BTN_AUTOREPEAT_EN to cover
// the auto-repeat variant.
//
// Cycle numbering: "cyc" counts rising clk edges. An input sampled at edge
// n belongs to cycle n; a registered output visible just after edge n
// belongs to cycle n+1.

module tb_button_event_decoder;

  localparam int L = 10;
  localparam int G = 4;
  localparam int R = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  // gesture phases of the model
  localparam int P_NONE   = 0;
  localparam int P_FIRST  = 1;
  localparam int P_GAP    = 2;
  localparam int P_SECOND = 3;
  localparam int P_LONG   = 4;

  logic clk;
  logic rst;
  logic btn_level;
  logic short_press;
  logic long_press;
  logic double_click;
  logic repeat_tick;
  logic held;

  int n_cmp;
  int n_err;
  int cyc;

  // scoreboard: expected {short,long,double,tick,held} per cycle
  logic [4:0] exp_q[$];

  // monitor bookkeeping
  int n_short, n_long, n_dbl, n_tick, n_held;
  int last_short, last_long, last_dbl, held_start;
  int tick_times[$];
  logic held_d;

  button_event_decoder #(
    .LONG_CYCLES(L),
    .GAP_CYCLES(G),
    .REPEAT_CYCLES(R),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_level(btn_level),
    .short_press(short_press),
    .long_press(long_press),
    .double_click(double_click),
    .repeat_tick(repeat_tick),
    .held(held)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  // Tracks the gesture as timestamps: when the current phase began and how
  // many cycles have elapsed since, deciding each edge what the registered
  // outputs must be in the following cycle.
  initial begin : model
    int   phase;
    int   t0;
    logic prev;
    logic e_s, e_l, e_d, e_t;
    phase = P_NONE;
    t0    = 0;
    prev  = 1'b1;
    cyc   = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      e_s = 1'b0; e_l = 1'b0; e_d = 1'b0; e_t = 1'b0;
      if (!rst) begin
        phase = P_NONE;
        prev  = 1'b1;
      end else begin
        case (phase)
          P_NONE:   if (btn_level && !prev) begin phase = P_FIRST; t0 = cyc; end
          P_FIRST:  if (!btn_level) begin phase = P_GAP; t0 = cyc; end
                    else if (cyc - t0 == L) begin e_l = 1'b1; phase = P_LONG; t0 = cyc; end
          P_GAP:    if (btn_level) phase = P_SECOND;
                    else if (cyc - t0 == G) begin e_s = 1'b1; phase = P_NONE; end
          P_SECOND: if (!btn_level) begin e_d = 1'b1; phase = P_NONE; end
          P_LONG:   if (!btn_level) phase = P_NONE;
                    else if (AUTOREP && ((cyc - t0) % R == 0)) e_t = 1'b1;
          default:  phase = P_NONE;
        endcase
        prev = btn_level;
      end
      exp_q.push_back({e_s, e_l, e_d, e_t, (phase == P_LONG)});
    end
  end

  // ---------------- compare + monitor ----------------
  initial begin : compare
    logic [4:0] e;
    logic [4:0] a;
    n_short = 0; n_long = 0; n_dbl = 0; n_tick = 0; n_held = 0;
    last_short = -1; last_long = -1; last_dbl = -1; held_start = -1;
    held_d = 1'b0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {short_press, long_press, double_click, repeat_tick, held};
        n_cmp = n_cmp + 1;
        if (a !== e) begin
          n_err = n_err + 1;
          $display("FAIL model_cycle cycle=%0d got {s,l,d,t,h}=%b required=%b",
                   cyc + 1, a, e);
        end
      end
      if (short_press === 1'b1)  begin n_short++; last_short = cyc + 1; end
      if (long_press === 1'b1)   begin n_long++;  last_long  = cyc + 1; end
      if (double_click === 1'b1) begin n_dbl++;   last_dbl   = cyc + 1; end
      if (repeat_tick === 1'b1)  begin n_tick++;  tick_times.push_back(cyc + 1); end
      if (held === 1'b1) begin
        n_held++;
        if (!held_d) held_start = cyc + 1;
      end
      held_d = (held === 1'b1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input int got, input int req);
    n_cmp = n_cmp + 1;
    if (got != req) begin
      n_err = n_err + 1;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // Hold btn_level at b for n sampling edges; first = edge index of the
  // first sample. Inputs change 1 time unit after the falling edge.
  task automatic hold(input logic b, input int n, output int first);
    btn_level = b;
    first = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      if (i == 0) first = cyc;
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin : stim
    int t, r, d;
    int s0, l0, d0, k0, h0;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    btn_level = 1'b1;
    @(negedge clk); #1;

    // 1: reset with button held; the held button must be ignored
    hold(1'b1, 3, d);
    check("reset_outputs_zero",
          int'({short_press, long_press, double_click, repeat_tick, held}), 0);
    rst = 1'b1;
    s0 = n_short; l0 = n_long; d0 = n_dbl; k0 = n_tick; h0 = n_held;
    hold(1'b1, 30, d);
    hold(1'b0, 10, d);
    check("s1_no_pulses_after_held_reset",
          (n_short - s0) + (n_long - l0) + (n_dbl - d0) + (n_tick - k0) + (n_held - h0), 0);
    s0 = n_short;
    hold(1'b1, 3, t);
    hold(1'b0, 1, r);
    hold(1'b0, 10, d);
    check("s1_short_count", n_short - s0, 1);
    check("s1_short_time", last_short, r + 5);

    // 2: plain short press
    s0 = n_short; l0 = n_long; h0 = n_held;
    hold(1'b1, 3, t);
    hold(1'b0, 20, d);
    check("s2_short_count", n_short - s0, 1);
    check("s2_no_long", n_long - l0, 0);
    check("s2_no_held", n_held - h0, 0);

    // 3: long press
    s0 = n_short; l0 = n_long; h0 = n_held;
    hold(1'b1, 15, t);
    hold(1'b0, 1, r);
    hold(1'b0, 10, d);
    check("s3_long_count", n_long - l0, 1);
    check("s3_long_time", last_long, t + 11);
    check("s3_held_start", held_start, t + 11);
    check("s3_held_cycles", n_held - h0, 5);
    check("s3_no_short", n_short - s0, 0);

    // 4: double click
    s0 = n_short; d0 = n_dbl;
    hold(1'b1, 3, t);
    hold(1'b0, 2, d);
    hold(1'b1, 2, d);
    hold(1'b0, 1, r);
    hold(1'b0, 10, d);
    check("s4_double_count", n_dbl - d0, 1);
    check("s4_double_time", last_dbl, r + 1);
    check("s4_no_short", n_short - s0, 0);

    // 5: reset during the release gap discards the pending short press
    s0 = n_short;
    hold(1'b1, 3, t);
    hold(1'b0, 1, d);
    rst = 1'b0;
    hold(1'b0, 1, d);
    rst = 1'b1;
    hold(1'b0, 20, d);
    check("s5_no_short", n_short - s0, 0);
    check("s5_outputs_zero",
          int'({short_press, long_press, double_click, repeat_tick, held}), 0);
    s0 = n_short;
    hold(1'b1, 3, t);
    hold(1'b0, 1, r);
    hold(1'b0, 10, d);
    check("s5_fresh_short_time", last_short, r + 5);

    // 6: long hold with or without auto-repeat
    l0 = n_long; k0 = n_tick;
    tick_times.delete();
    hold(1'b1, 20, t);
    hold(1'b0, 1, d);
    hold(1'b0, 10, d);
    check("s6_long_time", last_long, t + 11);
`ifdef BTN_AUTOREPEAT_EN
    check("s6_tick_count", n_tick - k0, 3);
    if (tick_times.size() == 3) begin
      check("s6_tick0", tick_times[0], t + 14);
      check("s6_tick1", tick_times[1], t + 17);
      check("s6_tick2", tick_times[2], t + 20);
    end
`else
    check("s6_no_tick", n_tick - k0, 0);
`endif

    // random gestures with occasional reset pulses
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b0;
        hold(1'($urandom_range(0, 1)), $urandom_range(1, 2), d);
        rst = 1'b1;
      end
      hold(~btn_level, $urandom_range(1, 14), d);
    end
    hold(1'b0, 20, d);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
